// File: rtl/seq_pkg.sv
// Shared encodings for the serial "11" link: transmitter FSM states double as
// the downstream detector's state constants.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } seq_state_e;

  localparam logic [1:0] DET_PATTERN = 2'b11;

endpackage

// File: rtl/serial_seq_tx_if.sv
// Load/ready handshake plus serial-line outputs of the serial_seq_tx block.
interface serial_seq_tx_if #(
  parameter int WIDTH = 8
) ();
  localparam int PW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             X;
  logic             busy;
  logic             done;
  logic [PW-1:0]    pair_cnt;

  modport master (
    output din, load,
    input  ready, X, busy, done, pair_cnt
  );

  modport slave (
    input  din, load,
    output ready, X, busy, done, pair_cnt
  );
endinterface

// File: rtl/serial_seq_tx.sv
// Parallel-to-serial transmitter feeding the "11" detector: shifts a frame out
// on X, follows it with one 0 guard bit, and reports the frame's "11" pair count.
//
// state   | meaning
// S_IDLE  | waiting for load; X=0, ready=1
// S_SHIFT | frame bits on X, one per cycle
// S_GAP   | guard bit X=0, done pulse, pair_cnt updated
module serial_seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            RESET,
  serial_seq_tx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = CW + 1;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    run_q, run_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic             x_q, x_d;
  logic             done_q, done_d;

  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  // x_q still holds the previously sent bit, so it doubles as the pair predecessor
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    pair_d  = pair_q;
    x_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          state_d = S_SHIFT;
          x_d     = head_of(bus.din);
          sh_d    = shift_once(bus.din);
          cnt_d   = CW'(WIDTH - 1);
          run_d   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          done_d  = 1'b1;
          pair_d  = run_q;
        end else begin
          x_d   = head_of(sh_q);
          sh_d  = shift_once(sh_q);
          cnt_d = cnt_q - CW'(1);
          if (x_q && head_of(sh_q)) run_d = run_q + PW'(1);
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      pair_q  <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      pair_q  <= pair_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign bus.X        = x_q;
  assign bus.done     = done_q;
  assign bus.pair_cnt = pair_q;

endmodule
